// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload structs and the bubble
// (NOP) value each stage register presents when empty, flushed or in reset.
// Stage registers take these through NOP_VAL, sized with $bits(<stage>_t).
package pipe_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        BEQ   = 6'h04,
        LW    = 6'h23,
        SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        ADD   = 6'h20,
        SUB   = 6'h22,
        AND_F = 6'h24,
        OR_F  = 6'h25
    } funct_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        opcode_t     op;
        funct_t      funct;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [4:0]  wsel;
        logic        regwen;
    } idex_t;

    typedef struct packed {
        opcode_t     op;
        funct_t      funct;
        logic [31:0] alu_out;
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        regwen;
        logic        iREN;
        logic        dREN;
        logic        dWEN;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        regwen;
    } memwb_t;

    // Bubbles decode as a harmless R-type ADD to r0 with no write enabled;
    // the EX/MEM bubble keeps instruction fetch requested.
    localparam ifid_t IFID_NOP = '{instr: '0, pc4: '0};

    localparam idex_t IDEX_NOP = '{op: RTYPE, funct: ADD, rdat1: '0, rdat2: '0,
                                   imm: '0, wsel: '0, regwen: 1'b0};

    localparam exmem_t EXMEM_NOP = '{op: RTYPE, funct: ADD, alu_out: '0, wdat: '0,
                                     wsel: '0, regwen: 1'b0, iREN: 1'b1,
                                     dREN: 1'b0, dWEN: 1'b0};

    localparam memwb_t MEMWB_NOP = '{wdat: '0, wsel: '0, regwen: 1'b0};

    localparam int IFID_W  = $bits(ifid_t);
    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of a pipeline stage register. Holds one payload that
// arrived while the main entry was stalled; the top moves it into the main
// entry as soon as the main entry drains. Used only with PIPE_SKID_EN.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Skid occupancy: flush wins, a load fills it, an unload empties it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    // Skid payload capture.
    // NOTE: the payload is qualified by valid_q, so it needs no reset; leaving
    // it out keeps the datapath flops plain enables.
    always_ff @(posedge CLK) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake, synchronous flush to NOP_VAL and a side-capture port
// for late data (e.g. memory responses) that also clears CLR_MASK bits.
// Define PIPE_SKID_EN to add a skid entry and make in_ready a registered
// signal; otherwise in_ready is combinational from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_VAL  = '0,
    parameter int                SIDE_W   = 32,
    parameter logic [DATA_W-1:0] CLR_MASK = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              side_en,
    input  logic [SIDE_W-1:0] side_data,
    output logic [SIDE_W-1:0] side_out
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SIDE_W-1:0] side_q, side_d;
    logic              main_free;
    logic              in_fire;
    logic              out_fire;

    assign out_fire  = valid_q & out_ready;
    assign main_free = ~valid_q | out_ready;
    assign in_fire   = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_unload;
    logic [DATA_W-1:0] skid_data;

    assign in_ready = ~skid_valid;

    pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .CLK      (CLK),
        .nRST     (nRST),
        .flush_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (in_data),
        .valid_o  (skid_valid),
        .data_o   (skid_data)
    );
`else
    assign in_ready = main_free;
`endif

    // Main entry next state: flush, then refill/drain when free, otherwise
    // stall with optional side-capture.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        side_d  = side_q;
`ifdef PIPE_SKID_EN
        skid_load   = 1'b0;
        skid_unload = 1'b0;
`endif
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
            side_d  = '0;
        end else if (main_free) begin
`ifdef PIPE_SKID_EN
            // A waiting skid entry is older than anything upstream offers.
            if (skid_valid) begin
                valid_d     = 1'b1;
                data_d      = skid_data;
                side_d      = '0;
                skid_unload = 1'b1;
            end else
`endif
            if (in_fire) begin
                valid_d = 1'b1;
                data_d  = in_data;
                side_d  = '0;
            end else if (out_fire) begin
                valid_d = 1'b0;
                data_d  = NOP_VAL;
            end
        end else begin
            // Held and not draining: the only place side-capture applies.
            if (side_en) begin
                side_d = side_data;
                data_d = data_q & ~CLR_MASK;
            end
`ifdef PIPE_SKID_EN
            skid_load = in_fire;
`endif
        end
    end

    // Main entry state register.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!nRST) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
            side_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            side_q  <= side_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign side_out  = side_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DATA_W=8, NOP_VAL=A5, CLR_MASK=03).
// Directed stimulus pushes expected payloads into a queue; a monitor pops and
// compares on every output transfer. Build with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int               DATA_W   = 8;
    localparam int               SIDE_W   = 32;
    localparam logic [DATA_W-1:0] NOP_VAL  = 8'hA5;
    localparam logic [DATA_W-1:0] CLR_MASK = 8'h03;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              side_en;
    logic [SIDE_W-1:0] side_data;
    logic [SIDE_W-1:0] side_out;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [DATA_W-1:0] exp_q[$];

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .NOP_VAL  (NOP_VAL),
        .SIDE_W   (SIDE_W),
        .CLR_MASK (CLR_MASK)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .side_en   (side_en),
        .side_data (side_data),
        .side_out  (side_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected payload.
    always @(negedge CLK) begin
        if (nRST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {56'h0, out_data}, {56'h0, NOP_VAL ^ out_data ^ 8'hFF});
            end else begin
                check("scoreboard_data", {56'h0, out_data}, {56'h0, exp_q.pop_front()});
                pops++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int cycles;
        int pops_before;
        logic fire;

        nRST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; side_en = 1'b0; side_data = '0;
        step(); step();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, NOP_VAL);
        check("reset_side_out", side_out, '0);
        check("reset_in_ready", in_ready, 1'b1);
        #3 nRST = 1'b1;

        // Mid-stream reset: load entries while stalled, then reset drops them.
        in_valid = 1'b1; in_data = 8'h01; step();
        in_data = 8'h02; step();
        nRST = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_out_data", out_data, NOP_VAL);
        check("midreset_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        #2 nRST = 1'b1;

        // First transaction after reset: one-cycle latency.
        in_valid = 1'b1; in_data = 8'h3C; step();
        in_valid = 1'b0;
        check("first_out_valid", out_valid, 1'b1);
        check("first_out_data", out_data, 8'h3C);
        check("first_side_out", side_out, '0);
        exp_q.push_back(8'h3C);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("drained_out_valid", out_valid, 1'b0);
        check("drained_out_data", out_data, NOP_VAL);

        // Stall: 11 held, 22 offered (stalled upstream, or parked in skid).
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; step(); step();
        check("stall_out_data", out_data, 8'h11);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_in_ready", in_ready, 1'b0);
`ifdef PIPE_SKID_EN
        in_valid = 1'b0;
`endif
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        out_ready = 1'b1; step();
        in_valid = 1'b0; step();
        out_ready = 1'b0;
        check("stall_drained_valid", out_valid, 1'b0);
        check("stall_queue_empty", exp_q.size(), 0);

        // Flush over a held entry with a concurrent offer that must be dropped.
        in_valid = 1'b1; in_data = 8'h5A; step();
        in_valid = 1'b0;
        check("flush_pre_data", out_data, 8'h5A);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out_data", out_data, NOP_VAL);
        check("flush_side_out", side_out, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_no_replay", out_valid, 1'b0);
        end
        out_ready = 1'b0;

        // Side-capture on a held entry clears the CLR_MASK bits.
        in_valid = 1'b1; in_data = 8'hFF; step();
        in_valid = 1'b0;
        side_en = 1'b1; side_data = 32'hDEADBEEF; step();
        side_en = 1'b0;
        check("side_capture_data", out_data, 8'hFC);
        check("side_capture_side", side_out, 32'hDEADBEEF);
        side_en = 1'b1; side_data = 32'h12345678; step();
        side_en = 1'b0;
        check("side_overwrite_data", out_data, 8'hFC);
        check("side_overwrite_side", side_out, 32'h12345678);

        // Capture while the entry drains (and a new one loads) is ignored.
        exp_q.push_back(8'hFC);
        out_ready = 1'b1; side_en = 1'b1; side_data = 32'hCAFEF00D;
        in_valid = 1'b1; in_data = 8'hFF; step();
        out_ready = 1'b0; side_en = 1'b0; in_valid = 1'b0;
        check("side_ignored_data", out_data, 8'hFF);
        check("side_ignored_side", side_out, '0);
        exp_q.push_back(8'hFF);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Stream 0..99 against random back-pressure (about 30% low).
        pops_before = pops;
        i = 0;
        cycles = 0;
        while (i < 100 && cycles < 2000) begin
            out_ready = ($urandom_range(0, 9) >= 3);
            in_valid = 1'b1;
            in_data = 8'(i);
            #1;
            fire = in_ready;
            if (fire) begin
                exp_q.push_back(8'(i));
                i++;
            end
            @(posedge CLK);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        check("stream_sent_all", i, 100);
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            step();
            cycles++;
        end
        step();
        out_ready = 1'b0;
        check("stream_queue_empty", exp_q.size(), 0);
        check("stream_output_count", pops - pops_before, 100);
        check("stream_final_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an opaque payload bus with a valid/ready handshake, synchronous flush to a configurable bubble value, and a side-capture port that late-arriving data such as a memory response uses to update a held entry and clear its request bits. An optional 2-entry skid buffer, selected at compile time, breaks the combinational ready path between stages.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- NOP_VAL, '0, DATA_W-bit payload presented during reset, flush and bubbles
- SIDE_W, 32, side-capture data width (≥1)
- CLR_MASK, '0, DATA_W-bit mask; payload bits set here are cleared on side-capture
- CLK  input  1  clock, rising edge
- nRST  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  held entry valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  held payload
- flush  input  1  synchronous squash of all held entries
- side_en  input  1  side-capture strobe
- side_data  input  SIDE_W  side-capture value
- side_out  output  SIDE_W  captured side value of the held entry

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Base mode, no skid: in_ready = out_ready | ~out_valid, combinational.
- On in_fire: out_data ← in_data, out_valid ← 1, side_out ← '0.
- On out_fire without in_fire: out_valid ← 0, out_data ← NOP_VAL.
- Otherwise the entry holds, which is the stall.
- Side-capture applies only when out_valid & ~out_fire:
  - side_out ← side_data
  - out_data ← out_data & ~CLR_MASK
  - Ignored when no entry is held or the entry drains this cycle.
  - Repeated strobes overwrite side_out; clearing is idempotent.
- Priority: nRST > flush > handshake/side-capture.
- Flush:
  - out_valid ← 0, out_data ← NOP_VAL, side_out ← '0.
  - Skid entry cleared.
  - Concurrent in_fire is dropped.
  - In skid mode in_ready is still driven, so upstream must also flush.
- Reset values, all outputs: out_valid 0, out_data NOP_VAL, side_out '0, in_ready 1.
- No arithmetic. All widths come from parameters; no truncation anywhere.

## Timing
- Latency is 1 cycle from in_fire to out_valid.
- Throughput is 1 entry/cycle when out_ready is held high.
- out_* are registered outputs, with no combinational path from in_* to out_*.
- A reset asserted mid-stall drops all entries immediately.
- Entries are not replayed after reset deasserts.

## Configuration
- PIPE_SKID_EN undefined: single entry, with the combinational in_ready above.
- PIPE_SKID_EN defined:
  - Adds a 2nd (skid) entry, so in_ready is a registered signal equal to ~skid_valid.
  - If in_fire occurs while the main entry is held and not draining, the payload goes to skid.
  - When the main entry drains, skid moves to main on the next edge.
  - Order is preserved.
  - Side-capture targets the main entry only.
  - Latency is unchanged and throughput stays at 1/cycle.

## Structure
- Shared package pipe_pkg holds the per-stage payload struct typedefs (ifid_t, idex_t, exmem_t, memwb_t).
- pipe_pkg also holds the corresponding NOP constants (e.g. EXMEM_NOP with op=RTYPE, funct=ADD, iREN=1), used as NOP_VAL via $bits casts.
- Sub-module pipe_skid_buf holds the skid entry and its valid bit.
- pipe_skid_buf is instantiated only under PIPE_SKID_EN.

## Test plan
- Reset and drain, DATA_W=8, NOP_VAL=8'hA5:
  - Assert nRST=0 mid-stream → out_valid=0, out_data=A5, in_ready=1 immediately.
  - Release reset and drive in_data=3C with in_valid=1 → next edge gives out_valid=1, out_data=3C.
- Stall:
  - With out_ready=0, drive 11 then 22 → out_data stays 11.
  - Base mode: in_ready=0.
  - Skid mode: 22 is held; raise out_ready → outputs 11, then 22, in order.
- Flush over a held entry:
  - Flush while holding 5A with in_valid=1, in_data=77 → next cycle out_valid=0, out_data=NOP_VAL.
  - 77 never appears.
- Side-capture, CLR_MASK=8'h03:
  - Hold 8'hFF with out_ready=0, pulse side_en with side_data=32'hDEADBEEF → out_data=FC, side_out=DEADBEEF.
  - Same stimulus with out_ready=1 → capture ignored.
- Stream 0..99 with random out_ready (30% low) in both configs → output sequence is exactly 0..99 with no duplicates.
